costas_mixer_iad: RTL and testbench

Parametrised Costas-loop arm mixer for the carrier-recovery chain. It multiplies the incoming baseband/IF sample by the NCO cosine and sine references to form the I and Q arms. An optional integrate-and-dump stage averages 2^IAD_LOG2 products per arm, acting as the arm low-pass and decimator. Results are rounded and saturated to OW bits before they go to the phase detector / loop filter. This block replaces the fixed 16-bit, truncating, always-enabled mixer pair.

---
 rtl/costas_pkg.sv | 54 +++++
 rtl/costas_mixer_iad_if.sv | 36 +++
 rtl/costas_mixer_iad_arm.sv | 94 +++++++++
 rtl/costas_mixer_iad.sv | 109 ++++++++++
 tb/tb_costas_mixer_iad.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/costas_pkg.sv
// costas_pkg
//   Shared definitions for the Costas-loop arm mixer.
//   - Default widths (sample, NCO reference, output, integrate-and-dump log2).
//   - mode_e: arm operating mode (per-sample bypass or integrate-and-dump).
//   - round_sat(): round-half-up arithmetic right shift, then clip to a signed
//     OW-bit range. It returns the clipped value and a flag that is set when
//     clipping occurred.
package costas_pkg;

    localparam int COSTAS_DW       = 16;
    localparam int COSTAS_CW       = 16;
    localparam int COSTAS_OW       = 16;
    localparam int COSTAS_IAD_LOG2 = 3;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_IAD    = 1'b1
    } mode_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               clip;
    } round_sat_t;

    // The 64-bit working width is ample for every legal parameter set.
    // The widest intermediate value is DW+CW+IAD_LOG2 bits plus the rounding
    // constant. The caller guarantees that shift >= 1.
    function automatic round_sat_t round_sat(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 ow
    );
        round_sat_t         res;
        logic signed [63:0] rounded;
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = value + (64'sd1 <<< (shift - 1));
        shifted = rounded >>> shift;
        max_v   = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (ow - 1));
        res.clip  = 1'b0;
        res.value = shifted;
        if (shifted > max_v) begin
            res.value = max_v;
            res.clip  = 1'b1;
        end else if (shifted < min_v) begin
            res.value = min_v;
            res.clip  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/costas_mixer_iad_if.sv
// costas_mixer_iad_if
//   Sample/result bundle of the Costas arm mixer.
//   master (sample source / result sink):
//     drives  clr, in_valid, s_in, lo_cos, lo_sin, iad_en
//     reads   out_valid, i_out, q_out, sat
//   slave (the mixer): the same signals with the directions reversed.
interface costas_mixer_iad_if
    import costas_pkg::*;
#(
    parameter int DW = COSTAS_DW,
    parameter int CW = COSTAS_CW,
    parameter int OW = COSTAS_OW
) ();

    logic                 clr;
    logic                 in_valid;
    logic signed [DW-1:0] s_in;
    logic signed [CW-1:0] lo_cos;
    logic signed [CW-1:0] lo_sin;
    logic                 iad_en;
    logic                 out_valid;
    logic signed [OW-1:0] i_out;
    logic signed [OW-1:0] q_out;
    logic                 sat;

    modport master (
        output clr, in_valid, s_in, lo_cos, lo_sin, iad_en,
        input  out_valid, i_out, q_out, sat
    );

    modport slave (
        input  clr, in_valid, s_in, lo_cos, lo_sin, iad_en,
        output out_valid, i_out, q_out, sat
    );

endinterface

// File: rtl/costas_mixer_iad_arm.sv
// costas_arm
//   One mixer arm. It contains three pieces:
//   - a full-precision product register (stage 1);
//   - an integrate-and-dump accumulator (stage 2);
//   - a round/saturate result register.
//   Ports:
//     clk, reset     clock, asynchronous active-low reset
//     i_clr          synchronous clear of the product path and accumulator
//     i_take         load a new product this cycle (in_valid and not clr)
//     i_s, i_lo      signed sample and NCO reference
//     i_p_valid      stage-1 product is valid
//     i_iad          effective block mode for the stage-1 product
//     i_last         stage-1 product is the last one of its block
//     i_out_en       register a result this cycle
//     o_res, o_clip  registered result and its clip flag
module costas_arm
    import costas_pkg::*;
#(
    parameter int DW       = COSTAS_DW,
    parameter int CW       = COSTAS_CW,
    parameter int OW       = COSTAS_OW,
    parameter int IAD_LOG2 = COSTAS_IAD_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_take,
    input  logic signed [DW-1:0] i_s,
    input  logic signed [CW-1:0] i_lo,
    input  logic                 i_p_valid,
    input  logic                 i_iad,
    input  logic                 i_last,
    input  logic                 i_out_en,
    output logic signed [OW-1:0] o_res,
    output logic                 o_clip
);

    localparam int PW      = DW + CW;
    localparam int AW      = PW + IAD_LOG2;
    localparam int S_BYP   = DW + CW - OW - 1;
    localparam int S_IAD   = IAD_LOG2 + DW + CW - OW - 1;

    logic signed [PW-1:0] r_p;
    logic signed [AW-1:0] r_acc;
    logic signed [OW-1:0] r_res;
    logic                 r_clip;

    logic signed [AW-1:0] w_sum;
    logic signed [63:0]   w_pre;
    round_sat_t           w_rs;

    // The sum of a full block of products needs no more than IAD_LOG2 extra bits.
    assign w_sum = r_acc + AW'(r_p);

    always_comb begin
        w_pre = 64'sd0;
        w_rs  = '0;
        if (i_iad) begin
            w_pre = 64'(w_sum);
            w_rs  = round_sat(w_pre, S_IAD, OW);
        end else begin
            w_pre = 64'(r_p);
            w_rs  = round_sat(w_pre, S_BYP, OW);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p    <= '0;
            r_acc  <= '0;
            r_res  <= '0;
            r_clip <= 1'b0;
        end else if (i_clr) begin
            // Results hold. Only the partial block is thrown away.
            r_acc <= '0;
        end else begin
            if (i_take) begin
                r_p <= PW'(i_s) * PW'(i_lo);
            end
            // In bypass mode the accumulator is never written, so it stays 0.
            if (i_p_valid && i_iad) begin
                r_acc <= i_last ? '0 : w_sum;
            end
            if (i_out_en) begin
                r_res  <= w_rs.value[OW-1:0];
                r_clip <= w_rs.clip;
            end
        end
    end

    assign o_res  = r_res;
    assign o_clip = r_clip;

endmodule

// File: rtl/costas_mixer_iad.sv
// costas_mixer_iad
//   Costas-loop arm mixer. It multiplies the sample by the NCO cosine and sine.
//   An optional integrate-and-dump stage averages 2^IAD_LOG2 products.
//   Results are rounded and saturated to OW bits.
//   Ports:
//     clk    clock; all state changes on the rising edge
//     reset  asynchronous, active-low reset
//     bus    costas_mixer_iad_if.slave (sample in, result out, clr, iad_en)
//   This level owns the valid pipeline, the block counter, the mode latch and
//   the OR of the two arm clip flags. It instantiates two costas_arm:
//   index 0 is the I arm (cosine) and index 1 is the Q arm (sine).
module costas_mixer_iad
    import costas_pkg::*;
#(
    parameter int DW       = COSTAS_DW,
    parameter int CW       = COSTAS_CW,
    parameter int OW       = COSTAS_OW,
    parameter int IAD_LOG2 = COSTAS_IAD_LOG2
) (
    input  logic clk,
    input  logic reset,
    costas_mixer_iad_if.slave bus
);

    logic                r_p_valid;
    mode_e               r_mode_s1;   // iad_en captured alongside the product
    mode_e               r_mode;      // mode held for the current block
    logic [IAD_LOG2-1:0] r_cnt;
    logic                r_out_valid;

    logic                 w_take;
    mode_e                w_mode_eff;
    logic                 w_last;
    logic                 w_out_en;
    logic signed [CW-1:0] w_lo   [2];
    logic signed [OW-1:0] w_res  [2];
    logic [1:0]           w_clip;

    // clr wins over a coincident sample.
    assign w_take = bus.in_valid & ~bus.clr;

    // At a block start the sample's own iad_en decides the mode. After that,
    // the latched mode applies until the counter wraps.
    assign w_mode_eff = (r_cnt == '0) ? r_mode_s1 : r_mode;
    assign w_last     = (r_cnt == {IAD_LOG2{1'b1}});
    assign w_out_en   = r_p_valid & ((w_mode_eff == MODE_BYPASS) | w_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_valid   <= 1'b0;
            r_mode_s1   <= MODE_BYPASS;
            r_mode      <= MODE_BYPASS;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.clr) begin
            r_p_valid   <= 1'b0;
            r_mode      <= MODE_BYPASS;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_p_valid   <= bus.in_valid;
            r_out_valid <= w_out_en;
            if (bus.in_valid) begin
                r_mode_s1 <= bus.iad_en ? MODE_IAD : MODE_BYPASS;
            end
            if (r_p_valid) begin
                r_mode <= w_mode_eff;
                if (w_mode_eff == MODE_IAD) begin
                    r_cnt <= r_cnt + IAD_LOG2'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign w_lo[0] = bus.lo_cos;
    assign w_lo[1] = bus.lo_sin;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arm
            costas_arm #(
                .DW       (DW),
                .CW       (CW),
                .OW       (OW),
                .IAD_LOG2 (IAD_LOG2)
            ) u_arm (
                .clk       (clk),
                .reset     (reset),
                .i_clr     (bus.clr),
                .i_take    (w_take),
                .i_s       (bus.s_in),
                .i_lo      (w_lo[gi]),
                .i_p_valid (r_p_valid),
                .i_iad     (w_mode_eff == MODE_IAD),
                .i_last    (w_last),
                .i_out_en  (w_out_en),
                .o_res     (w_res[gi]),
                .o_clip    (w_clip[gi])
            );
        end
    endgenerate

    assign bus.out_valid = r_out_valid;
    assign bus.i_out     = w_res[0];
    assign bus.q_out     = w_res[1];
    assign bus.sat       = |w_clip;

endmodule

// File: tb/tb_costas_mixer_iad.sv
module tb_costas_mixer_iad;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    costas_mixer_iad_if #(.DW(16), .CW(16), .OW(16)) bus ();

    costas_mixer_iad #(.DW(16), .CW(16), .OW(16), .IAD_LOG2(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] s, input logic signed [15:0] c,
                        input logic signed [15:0] sn);
        bus.s_in     = s;
        bus.lo_cos   = c;
        bus.lo_sin   = sn;
        bus.in_valid = 1'b1;
        $display("txn sample: s_in=%0d lo_cos=%0d lo_sin=%0d iad_en=%0b clr=%0b",
                 s, c, sn, bus.iad_en, bus.clr);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.iad_en = 1'b0;
        bus.s_in = '0; bus.lo_cos = '0; bus.lo_sin = '0;
        repeat (3) step();
        $display("txn reset: out_valid=%0b i_out=%0d q_out=%0d sat=%0b", bus.out_valid, bus.i_out, bus.q_out, bus.sat);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL reset_i_out got %0d want 0", bus.i_out); end
        n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL reset_q_out got %0d want 0", bus.q_out); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %0b want 0", bus.sat); end
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_bypass();
        bus.iad_en = 1'b0;
        send(16'sd16384, 16'sd16384, -16'sd16384);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_latency1 out_valid got %0b want 0", bus.out_valid); end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d sat=%0b", bus.out_valid, bus.i_out, bus.q_out, bus.sat);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_out_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL byp_i_out got %0d want 8192", bus.i_out); end
        n_checks++; if (bus.q_out !== -16'sd8192) begin n_fail++; $display("FAIL byp_q_out got %0d want -8192", bus.q_out); end
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL byp_sat got %0b want 0", bus.sat); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_pulse got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL byp_hold got %0d want 8192", bus.i_out); end
    endtask

    task automatic test_rounding();
        bus.iad_en = 1'b0;
        // 1*16384 = 2^14 is exactly half an LSB, so it rounds up to 1.
        send(16'sd1, 16'sd16384, 16'sd16384);
        // -2^14 is half an LSB below zero, so it rounds up to 0.
        send(-16'sd1, 16'sd16384, 16'sd16384);
        $display("txn result: i_out=%0d q_out=%0d", bus.i_out, bus.q_out);
        n_checks++; if (bus.i_out !== 16'sd1) begin n_fail++; $display("FAIL round_half_up got %0d want 1", bus.i_out); end
        n_checks++; if (bus.q_out !== 16'sd1) begin n_fail++; $display("FAIL round_half_up_q got %0d want 1", bus.q_out); end
        // 16383 is just under half an LSB, so it rounds down to 0.
        send(16'sd1, 16'sd16383, 16'sd16384);
        $display("txn result: i_out=%0d q_out=%0d", bus.i_out, bus.q_out);
        n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL round_neg_half got %0d want 0", bus.i_out); end
        step();
        $display("txn result: i_out=%0d q_out=%0d", bus.i_out, bus.q_out);
        n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL round_below_half got %0d want 0", bus.i_out); end
        n_checks++; if (bus.q_out !== 16'sd1) begin n_fail++; $display("FAIL round_below_half_q got %0d want 1", bus.q_out); end
        step();
    endtask

    task automatic test_saturation();
        bus.iad_en = 1'b0;
        send(-16'sd32768, -16'sd32768, 16'sd32767);
        send(16'sd16384, 16'sd16384, -16'sd16384);
        $display("txn result: i_out=%0d q_out=%0d sat=%0b", bus.i_out, bus.q_out, bus.sat);
        n_checks++; if (bus.i_out !== 16'sd32767) begin n_fail++; $display("FAIL sat_i_out got %0d want 32767", bus.i_out); end
        n_checks++; if (bus.q_out !== -16'sd32767) begin n_fail++; $display("FAIL sat_q_out got %0d want -32767", bus.q_out); end
        n_checks++; if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %0b want 1", bus.sat); end
        step();
        n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0b want 0", bus.sat); end
        step();
    endtask

    task automatic test_iad();
        bus.iad_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send(16'sd16384, 16'sd16384, -16'sd16384);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL iad_early sample %0d out_valid got %0b want 0", k, bus.out_valid); end
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL iad_out_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL iad_i_out got %0d want 8192", bus.i_out); end
        n_checks++; if (bus.q_out !== -16'sd8192) begin n_fail++; $display("FAIL iad_q_out got %0d want -8192", bus.q_out); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL iad_pulse got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_gaps();
        bus.iad_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send(16'sd8192, 16'sd16384, -16'sd16384);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early sample %0d got %0b want 0", k, bus.out_valid); end
            if (k != 8) step();
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_out_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd4096) begin n_fail++; $display("FAIL gap_i_out got %0d want 4096", bus.i_out); end
        n_checks++; if (bus.q_out !== -16'sd4096) begin n_fail++; $display("FAIL gap_q_out got %0d want -4096", bus.q_out); end
        step();
    endtask

    task automatic test_mode_change();
        bus.iad_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) bus.iad_en = 1'b0;
            send(16'sd16384, 16'sd16384, 16'sd16384);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mode_hold sample %0d out_valid got %0b want 0", k, bus.out_valid); end
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mode_out_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.q_out !== 16'sd8192) begin n_fail++; $display("FAIL mode_q_out got %0d want 8192", bus.q_out); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.iad_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 8) send(16'sd16384, 16'sd16384, -16'sd16384);
            else        send(16'sd8192, 16'sd16384, 16'sd16384);
            n_checks++; if (bus.out_valid !== (k == 9)) begin n_fail++; $display("FAIL b2b_valid sample %0d got %0b want %0b", k, bus.out_valid, (k == 9)); end
            if (k == 9) begin
                $display("txn result: i_out=%0d q_out=%0d", bus.i_out, bus.q_out);
                n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL b2b_first_i got %0d want 8192", bus.i_out); end
            end
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd4096) begin n_fail++; $display("FAIL b2b_second_i got %0d want 4096", bus.i_out); end
        n_checks++; if (bus.q_out !== 16'sd4096) begin n_fail++; $display("FAIL b2b_second_q got %0d want 4096", bus.q_out); end
        step();
    endtask

    task automatic test_reset_mid_block();
        bus.iad_en = 1'b1;
        repeat (5) send(16'sd32767, 16'sd32767, 16'sd32767);
        reset = 1'b0;
        #3;
        $display("txn reset: out_valid=%0b i_out=%0d q_out=%0d sat=%0b", bus.out_valid, bus.i_out, bus.q_out, bus.sat);
        n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL rst_mid_i_out got %0d want 0", bus.i_out); end
        n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL rst_mid_q_out got %0d want 0", bus.q_out); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %0b want 0", bus.out_valid); end
        step();
        reset = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            send(16'sd8192, 16'sd16384, 16'sd16384);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_early sample %0d got %0b want 0", k, bus.out_valid); end
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_result_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd4096) begin n_fail++; $display("FAIL rst_mid_result_i got %0d want 4096", bus.i_out); end
        step();
    endtask

    task automatic test_clr();
        bus.iad_en = 1'b1;
        repeat (3) send(16'sd32767, 16'sd32767, 16'sd32767);
        bus.clr = 1'b1;
        send(16'sd32767, 16'sd32767, 16'sd32767);
        bus.clr = 1'b0;
        n_checks++; if (bus.i_out !== 16'sd4096) begin n_fail++; $display("FAIL clr_hold got %0d want 4096", bus.i_out); end
        for (int k = 1; k <= 8; k++) begin
            send(16'sd16384, 16'sd16384, -16'sd16384);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_early sample %0d got %0b want 0", k, bus.out_valid); end
        end
        step();
        $display("txn result: out_valid=%0b i_out=%0d q_out=%0d", bus.out_valid, bus.i_out, bus.q_out);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_result_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL clr_result_i got %0d want 8192", bus.i_out); end
        n_checks++; if (bus.q_out !== -16'sd8192) begin n_fail++; $display("FAIL clr_result_q got %0d want -8192", bus.q_out); end
        // A bypass product in flight is dropped by clr, and the outputs hold.
        bus.iad_en = 1'b0;
        send(16'sd8192, 16'sd16384, 16'sd16384);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        $display("txn clr: out_valid=%0b i_out=%0d", bus.out_valid, bus.i_out);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drop_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.i_out !== 16'sd8192) begin n_fail++; $display("FAIL clr_drop_hold got %0d want 8192", bus.i_out); end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_bypass();
        test_rounding();
        test_saturation();
        test_iad();
        test_gaps();
        test_mode_change();
        test_back_to_back();
        test_reset_mid_block();
        test_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
